// File: rtl/sram_if_pkg.sv
// rtl/sram_if_pkg.sv - shared types and constants for the SRAM responder and controller
package sram_if_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    READ_WAIT  = 2'd2,
    READ_DRIVE = 2'd3
  } state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 4;
  localparam int READ_LAT_MAX = 3;
  localparam int LAT_W        = $clog2(READ_LAT_MAX + 1);

endpackage

// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - SRAM control/data bus between cycle controller and responder
interface sram_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              latch;
  logic              count;
  logic [ADDR_W-1:0] addr_in;
  logic              de;
  logic              n_ce;
  logic              n_oe;
  logic              n_we;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [ADDR_W-1:0] addr;
  logic              conflict;
  logic [15:0]       wr_cnt;
  logic [15:0]       rd_cnt;

  modport master (
    output latch, count, addr_in, de, n_ce, n_oe, n_we, data_in,
    input  data_out, data_oe, addr, conflict, wr_cnt, rd_cnt
  );

  modport slave (
    input  latch, count, addr_in, de, n_ce, n_oe, n_we, data_in,
    output data_out, data_oe, addr, conflict, wr_cnt, rd_cnt
  );
endinterface

// File: rtl/sram_addr_ctr.sv
// rtl/sram_addr_ctr.sv - loadable wrapping address counter; load has priority over increment
module sram_addr_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] addr
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (inc) begin
      addr <= addr + W'(1);
    end
  end

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - SRAM memory-side responder; SRAM_RESP_STATS_EN adds write/read counters
module sram_responder
  import sram_if_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int READ_LAT = 1
) (
  input logic             clk,
  input logic             n_rst,
  sram_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] capture;
  logic [DATA_W-1:0] data_out;
  logic              captured;
  logic              data_oe;
  logic              conflict;
  logic              sel;
  logic              both;
  logic              commit;
  logic              rd_start;

  sram_addr_ctr #(.W(ADDR_W)) u_addr_ctr (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (bus.latch),
    .inc      (bus.count),
    .load_val (bus.addr_in),
    .addr     (addr)
  );

  assign sel      = ~bus.n_ce;
  assign both     = sel & ~bus.n_oe & ~bus.n_we;
  assign commit   = (state == WRITE) & sel & bus.n_we & captured;
  assign rd_start = (state == READ_WAIT) & sel & ~bus.n_oe & bus.n_we & (lat_cnt == '0);

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[addr] <= capture;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      capture  <= '0;
      captured <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
      conflict <= 1'b0;
    end else begin
      if (both) begin
        conflict <= 1'b1;
      end
      case (state)
        IDLE: begin
          captured <= 1'b0;
          if (sel && !bus.n_we) begin
            state <= WRITE;
          end else if (sel && !bus.n_oe) begin
            state   <= READ_WAIT;
            lat_cnt <= LAT_W'(READ_LAT - 1);
          end
        end
        WRITE: begin
          // n_ce high aborts; n_we high with n_ce low ends the pulse (commit handled above)
          if (!sel || bus.n_we) begin
            captured <= 1'b0;
            state    <= IDLE;
          end else if (bus.de) begin
            capture  <= bus.data_in;
            captured <= 1'b1;
          end
        end
        READ_WAIT: begin
          if (both) begin
            state <= WRITE;
          end else if (!sel || bus.n_oe) begin
            state <= IDLE;
          end else if (rd_start) begin
            data_out <= mem[addr];
            data_oe  <= 1'b1;
            state    <= READ_DRIVE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        READ_DRIVE: begin
          if (both) begin
            data_oe <= 1'b0;
            state   <= WRITE;
          end else if (!sel || bus.n_oe) begin
            data_oe <= 1'b0;
            state   <= IDLE;
          end else begin
            data_out <= mem[addr];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out = data_out;
  assign bus.data_oe  = data_oe;
  assign bus.addr     = addr;
  assign bus.conflict = conflict;

`ifdef SRAM_RESP_STATS_EN
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (commit && wr_cnt != 16'hFFFF) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
      if (rd_start && rd_cnt != 16'hFFFF) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

  assign bus.wr_cnt = wr_cnt;
  assign bus.rd_cnt = rd_cnt;
`else
  assign bus.wr_cnt = '0;
  assign bus.rd_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed self-checking bench for sram_responder (READ_LAT=2)
module tb_sram_responder;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_fail;

  sram_responder_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  sram_responder #(
    .DATA_W   (8),
    .ADDR_W   (4),
    .READ_LAT (2)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_latch(input logic [3:0] a);
    bus.addr_in = a;
    bus.latch   = 1'b1;
    tick(1);
    bus.latch   = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] d, input logic use_de);
    bus.n_ce    = 1'b0;
    bus.n_we    = 1'b0;
    bus.de      = use_de;
    bus.data_in = d;
    tick(2);
    bus.n_we    = 1'b1;
    bus.de      = 1'b0;
    tick(1);
    bus.n_ce    = 1'b1;
  endtask

  task automatic do_read(input string tag, input logic [7:0] exp);
    bus.n_ce = 1'b0;
    bus.n_oe = 1'b0;
    tick(1);
    check({tag, "_oe_lat0"}, bus.data_oe, 1'b0);
    tick(1);
    check({tag, "_oe_lat1"}, bus.data_oe, 1'b0);
    tick(1);
    check({tag, "_oe_lat2"}, bus.data_oe, 1'b1);
    check({tag, "_data"}, bus.data_out, exp);
    bus.n_oe = 1'b1;
    tick(1);
    check({tag, "_oe_off"}, bus.data_oe, 1'b0);
    check({tag, "_data_hold"}, bus.data_out, exp);
    bus.n_ce = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    n_rst       = 1'b0;
    bus.latch   = 1'b0;
    bus.count   = 1'b0;
    bus.addr_in = '0;
    bus.de      = 1'b0;
    bus.n_ce    = 1'b1;
    bus.n_oe    = 1'b1;
    bus.n_we    = 1'b1;
    bus.data_in = '0;
    tick(2);
    check("rst_addr", bus.addr, 4'd0);
    check("rst_data_oe", bus.data_oe, 1'b0);
    check("rst_data_out", bus.data_out, 8'h00);
    check("rst_conflict", bus.conflict, 1'b0);
    check("rst_wr_cnt", bus.wr_cnt, 16'd0);
    check("rst_rd_cnt", bus.rd_cnt, 16'd0);
    n_rst = 1'b1;
    tick(1);

    // Single write then latency-2 read
    do_latch(4'd3);
    check("latch_addr", bus.addr, 4'd3);
    do_write(8'hA5, 1'b1);
    do_read("rd_a5", 8'hA5);
    check("no_conflict", bus.conflict, 1'b0);

    // Burst across the 15 -> 0 wrap
    do_latch(4'd14);
    for (int i = 0; i < 4; i++) begin
      do_write(8'h10 + 8'(i), 1'b1);
      if (i < 3) begin
        bus.count = 1'b1;
        tick(1);
        bus.count = 1'b0;
      end
    end
    check("burst_wrap_addr", bus.addr, 4'd1);
    do_latch(4'd14);
    bus.n_ce = 1'b0;
    bus.n_oe = 1'b0;
    tick(3);
    check("burst_oe", bus.data_oe, 1'b1);
    check("burst_d0", bus.data_out, 8'h10);
    for (int i = 1; i < 4; i++) begin
      bus.count = 1'b1;
      tick(1);
      check("burst_prev", bus.data_out, 8'h10 + 8'(i - 1));
      bus.count = 1'b0;
      tick(1);
      check("burst_next", bus.data_out, 8'h10 + 8'(i));
    end
    bus.n_oe = 1'b1;
    tick(1);
    check("burst_oe_off", bus.data_oe, 1'b0);
    bus.n_ce = 1'b1;

    // latch beats count; dropped and aborted writes leave memory alone
    bus.addr_in = 4'd7;
    bus.latch   = 1'b1;
    bus.count   = 1'b1;
    tick(1);
    bus.latch   = 1'b0;
    bus.count   = 1'b0;
    check("latch_prio", bus.addr, 4'd7);
    do_write(8'h5A, 1'b1);
    do_write(8'hFF, 1'b0);
    do_read("rd_no_de", 8'h5A);
    bus.n_ce    = 1'b0;
    bus.n_we    = 1'b0;
    bus.de      = 1'b1;
    bus.data_in = 8'hC3;
    tick(2);
    bus.n_ce    = 1'b1;
    tick(1);
    bus.n_we    = 1'b1;
    bus.de      = 1'b0;
    tick(1);
    do_read("rd_abort", 8'h5A);

    // Conflict during READ_DRIVE: write wins
    do_latch(4'd3);
    bus.n_ce = 1'b0;
    bus.n_oe = 1'b0;
    tick(3);
    check("cf_pre_oe", bus.data_oe, 1'b1);
    check("cf_pre_flag", bus.conflict, 1'b0);
    bus.n_we    = 1'b0;
    bus.de      = 1'b1;
    bus.data_in = 8'h3C;
    tick(1);
    check("cf_flag", bus.conflict, 1'b1);
    check("cf_oe_drop", bus.data_oe, 1'b0);
    tick(1);
    bus.n_we = 1'b1;
    bus.n_oe = 1'b1;
    bus.de   = 1'b0;
    tick(1);
    bus.n_ce = 1'b1;
    tick(1);
    check("cf_sticky", bus.conflict, 1'b1);
    do_read("rd_cf", 8'h3C);
    check("cf_sticky2", bus.conflict, 1'b1);

`ifdef SRAM_RESP_STATS_EN
    check("stat_wr", bus.wr_cnt, 16'd7);
    check("stat_rd", bus.rd_cnt, 16'd6);
`else
    check("stat_wr", bus.wr_cnt, 16'd0);
    check("stat_rd", bus.rd_cnt, 16'd0);
`endif

    // Asynchronous reset mid-READ_DRIVE; memory survives
    do_latch(4'd3);
    bus.n_ce = 1'b0;
    bus.n_oe = 1'b0;
    tick(3);
    check("rst2_pre_oe", bus.data_oe, 1'b1);
    #1;
    n_rst = 1'b0;
    #1;
    check("rst2_oe", bus.data_oe, 1'b0);
    check("rst2_addr", bus.addr, 4'd0);
    check("rst2_conflict", bus.conflict, 1'b0);
    check("rst2_data_out", bus.data_out, 8'h00);
    check("rst2_wr_cnt", bus.wr_cnt, 16'd0);
    bus.n_oe = 1'b1;
    bus.n_ce = 1'b1;
    tick(1);
    n_rst = 1'b1;
    tick(1);
    do_latch(4'd3);
    do_read("rd_after_rst", 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the SRAM control interface that the read/write cycle controller drives (latch, count, de, n_ce, n_oe, n_we).
- Holds a synthesizable memory array and an address register that is loaded by latch and incremented by count.
- Commits writes on the trailing edge of n_we and drives read data after a programmable latency while n_oe is low.
- Used as the on-chip target for bring-up and as the bench partner for the controller.

Parameters:
DATA_W, 8, data bus width
ADDR_W, 4, address width; memory depth is 2**ADDR_W
READ_LAT, 1, cycles from the n_oe-low sample to valid data_out; legal range 1..3

Ports:
clk  in  1  single clock, rising edge
n_rst  in  1  asynchronous active-low reset
latch  in  1  load addr from addr_in
count  in  1  increment addr
addr_in  in  ADDR_W  address to load
de  in  1  controller is driving data_in
n_ce  in  1  chip enable, active low
n_oe  in  1  output enable, active low
n_we  in  1  write enable, active low
data_in  in  DATA_W  write data
data_out  out  DATA_W  read data
data_oe  out  1  data_out valid/drive enable
addr  out  ADDR_W  current address register
conflict  out  1  sticky: n_oe and n_we both low with n_ce low
wr_cnt  out  16  committed write count (optional feature)
rd_cnt  out  16  read access count (optional feature)

Behaviour:
- Reset (n_rst low, asynchronous) clears the following; memory array is not reset:
  - addr=0, data_out=0, data_oe=0, conflict=0
  - state=IDLE, capture register=0, captured flag=0, wr_cnt=rd_cnt=0
- Address register:
  - latch=1: addr<=addr_in.
  - else count=1: addr<=addr+1, wrapping from 2**ADDR_W-1 to 0.
  - latch and count in the same cycle: latch wins.
  - Active in every state.
- FSM states: IDLE, WRITE, READ_WAIT, READ_DRIVE.
- IDLE:
  - n_ce=0 and n_we=0 -> WRITE (checked first).
  - else n_ce=0 and n_oe=0 -> READ_WAIT, loading the latency counter with READ_LAT-1.
- WRITE:
  - Each cycle with de=1: capture<=data_in and set the captured flag.
  - n_we sampled 1 with n_ce=0: if captured, mem[addr]<=capture (addr as of that cycle); clear the flag -> IDLE.
  - The write is dropped if de was never high during the pulse.
  - n_ce sampled 1 before n_we returns high: abort with no commit, clear the flag -> IDLE.
- READ_WAIT:
  - Decrement the counter each cycle.
  - At 0: data_out<=mem[addr], data_oe<=1 -> READ_DRIVE.
  - Latency: data_oe is high starting READ_LAT cycles after the first cycle n_oe is sampled low.
- READ_DRIVE:
  - Each cycle data_out<=mem[addr] (registered), so an address change from count shows up one cycle later.
  - n_oe=1 or n_ce=1 sampled: data_oe<=0 -> IDLE; data_out holds its last value.
- Abort in READ_WAIT: n_oe or n_ce goes high -> IDLE, data_oe stays 0, no read counted.
- Conflict:
  - n_ce=0, n_oe=0, n_we=0 in any state sets conflict (sticky until reset).
  - Write takes priority: from READ_* states go to WRITE with data_oe<=0 the next cycle.
- n_ce=1 in IDLE: all strobes are ignored; addr still responds to latch and count.

Optional Feature:
- Macro SRAM_RESP_STATS_EN.
- Defined:
  - wr_cnt increments on each committed write.
  - rd_cnt increments on each READ_WAIT->READ_DRIVE transition.
  - Both saturate at 16'hFFFF.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package sram_if_pkg holds:
  - state enum (IDLE, WRITE, READ_WAIT, READ_DRIVE)
  - default DATA_W/ADDR_W constants
  - READ_LAT_MAX=3
- One sub-module, sram_addr_ctr: addr register with load/increment/wrap, also reusable on the controller side.
- Memory array is inferred inline.

Test Plan:
1. Reset: n_rst low mid-READ_DRIVE -> data_oe=0, addr=0, conflict=0 immediately; memory contents preserved on later read.
2. Write/read: latch addr_in=3; n_we low 2 cycles with de=1, data_in=8'hA5; n_we high. Then n_oe low with READ_LAT=2 -> data_oe=1 and data_out=8'hA5 exactly 2 cycles after the first n_oe-low sample.
3. Burst with count:
   - Write 8'h10..8'h13 to addr 14,15,0,1 using count between pulses (wrap at 15->0).
   - Read back with count pulses -> 10,11,12,13, each one cycle after its count.
4. Priority and abort:
   - latch=1, count=1, addr_in=7 -> addr=7.
   - Write pulse with de never high -> location unchanged.
   - n_ce high mid-write -> no commit.
5. Conflict: n_oe and n_we both low with n_ce low during READ_DRIVE -> conflict=1 (sticky), data_oe=0 next cycle, write commits on n_we rise.
6. With SRAM_RESP_STATS_EN: 3 writes and 2 reads -> wr_cnt=3, rd_cnt=2. Without the macro: both read 0.
